// File: rtl/regfile_2r1w.sv
// regfile_2r1w
//   Register file with two registered read ports and one write port. After
//   reset or a clear pulse, the block zero-fills every entry, one entry per
//   clock, before it accepts any reads or writes.
//
//   Parameters
//     DATA_WIDTH   entry width in bits
//     ADDR_WIDTH   address width; DEPTH = 2**ADDR_WIDTH
//
//   Ports
//     clock                      rising-edge clock
//     reset                      asynchronous active-low reset
//     clear                      synchronous restart of the zero-fill
//     init_done                  storage initialised, ports accepted
//     write_en / write_address / write_data    write port
//     rdN_en / rdN_address       read request, ports 0 and 1
//     rdN_data / rdN_valid       registered read result; valid is a one-cycle pulse
//
//   Build option
//     REGFILE_BYPASS_EN  defined:   a same-cycle read of the address being
//                                   written returns write_data (write-first).
//                        undefined: that read returns the old entry (read-first).

// Per-port read pipeline: one register stage for data and valid.
module regfile_rd_port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             accept,
  input  logic                             en,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem,
  input  logic                             wr_fire,
  input  logic [ADDR_WIDTH-1:0]            write_address,
  input  logic [DATA_WIDTH-1:0]            write_data,
  output logic [DATA_WIDTH-1:0]            data,
  output logic                             valid
);

  logic [DATA_WIDTH-1:0] rd_value;

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight write so the read sees the new value.
  always_comb begin
    rd_value = mem[address];
    if (wr_fire && (write_address == address)) rd_value = write_data;
  end
`else
  // Read-first: the array still holds the old value at this edge.
  always_comb begin
    rd_value = mem[address];
  end

  // Write-side inputs only matter when forwarding is built in.
  logic unused_fwd;
  assign unused_fwd = ^{wr_fire, write_address, write_data};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= accept && en;
      // Data holds its last value whenever no read is accepted.
      if (accept && en) data <= rd_value;
    end
  end

endmodule

module regfile_2r1w #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  init_done,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  rd0_en,
  input  logic [ADDR_WIDTH-1:0] rd0_address,
  output logic [DATA_WIDTH-1:0] rd0_data,
  output logic                  rd0_valid,
  input  logic                  rd1_en,
  input  logic [ADDR_WIDTH-1:0] rd1_address,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic                  rd1_valid
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_PORTS = 2;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {INIT, IDLE} state_t;

  state_t                           state;
  logic [ADDR_WIDTH-1:0]            cnt;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  // A clear edge overrides everything, so nothing is accepted while it is high.
  logic accept;
  logic wr_fire;
  assign accept  = (state == IDLE) && !clear;
  assign wr_fire = accept && write_en;

  // Control FSM: INIT walks cnt over every entry, then IDLE serves the ports.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else if (clear) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;  // wraps back to 0 on the last entry
      if (cnt == LAST) begin
        state     <= IDLE;
        init_done <= 1'b1;
      end
    end
  end

  // Storage has no reset; the INIT fill is the only thing that zeroes it.
  always_ff @(posedge clock) begin
    if (!clear) begin
      if (state == INIT)  mem[cnt]           <= '0;
      else if (write_en)  mem[write_address] <= write_data;
    end
  end

  // Read ports, one instance per port.
  logic [NUM_PORTS-1:0]                 rd_en;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_dat;
  logic [NUM_PORTS-1:0]                 rd_vld;

  assign rd_en   = {rd1_en, rd0_en};
  assign rd_addr = {rd1_address, rd0_address};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
    regfile_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
    ) u_rd (
      .clock         (clock),
      .reset         (reset),
      .accept        (accept),
      .en            (rd_en[g]),
      .address       (rd_addr[g]),
      .mem           (mem),
      .wr_fire       (wr_fire),
      .write_address (write_address),
      .write_data    (write_data),
      .data          (rd_dat[g]),
      .valid         (rd_vld[g])
    );
  end

  assign rd0_data  = rd_dat[0];
  assign rd1_data  = rd_dat[1];
  assign rd0_valid = rd_vld[0];
  assign rd1_valid = rd_vld[1];

endmodule
